// File: rtl/alu_cmd_pkg.sv
// Shared types and defaults for the ALU command issuer: opcode encoding,
// issuer FSM states and the default datapath width.
package alu_cmd_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_AND  = 2'b10,
      OP_RSVD = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      RESP
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/alu_cmd_issuer_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Valid/ready front end for the 2-bit-opcode combinational ALU: registers a
// command onto the ALU inputs, captures the result a cycle later and returns it.
module alu_cmd_issuer
   import alu_cmd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_opcode,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [1:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [1:0]        rsp_opcode,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  err_count
);

   state_t state_reg;
   logic   ready_en_reg;
   logic   op_done;
   logic   err_done;

   // ready_en_reg keeps cmd_ready low while rst is held even though state is IDLE.
   always_comb begin
      cmd_ready = 1'b0;
      case (state_reg)
         IDLE:    cmd_ready = ready_en_reg;
         RESP:    cmd_ready = rsp_ready;
         default: cmd_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         ready_en_reg <= 1'b0;
         alu_opcode   <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_opcode   <= '0;
         rsp_err      <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  alu_opcode <= cmd_opcode;
                  alu_a      <= cmd_a;
                  alu_b      <= cmd_b;
                  state_reg  <= DRIVE;
               end
            end
            DRIVE: begin
               rsp_opcode <= alu_opcode;
               rsp_valid  <= 1'b1;
               state_reg  <= RESP;
               // The ALU output is undefined for the reserved opcode; never forward it.
               if (alu_opcode == OP_RSVD) begin
                  rsp_result <= '0;
                  rsp_err    <= 1'b1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_err    <= 1'b0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (cmd_valid) begin
                     alu_opcode <= cmd_opcode;
                     alu_a      <= cmd_a;
                     alu_b      <= cmd_b;
                     state_reg  <= DRIVE;
                  end else begin
                     state_reg  <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign op_done  = rsp_valid & rsp_ready;
   assign err_done = op_done & rsp_err;

   sat_counter #(.W(CNT_W)) u_op_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (op_done),
      .count (op_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_done),
      .count (err_count)
   );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed commands push expected
// responses, a negedge monitor pops and compares on every response handshake.
module tb_alu_cmd_issuer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_opcode = 2'b00;
   logic [7:0] cmd_a = 8'h00;
   logic [7:0] cmd_b = 8'h00;
   logic       rsp_ready = 1'b1;

   logic        cmd_ready, rsp_valid, rsp_err;
   logic [1:0]  alu_opcode, rsp_opcode;
   logic [7:0]  alu_a, alu_b, alu_result, rsp_result;
   logic [15:0] op_count, err_count;

   logic        cmd_ready2, rsp_valid2, rsp_err2;
   logic [1:0]  alu_opcode2, rsp_opcode2;
   logic [7:0]  alu_a2, alu_b2, alu_result2, rsp_result2;
   logic [1:0]  op_count2, err_count2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] res;
      logic [1:0] op;
      logic       err;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the existing ALU; reserved opcode yields garbage on purpose.
   function automatic logic [7:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return 8'hA5;
      endcase
   endfunction

   assign alu_result  = alu_model(alu_opcode, alu_a, alu_b);
   assign alu_result2 = alu_model(alu_opcode2, alu_a2, alu_b2);

   alu_cmd_issuer #(.DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
      .op_count(op_count), .err_count(err_count)
   );

   // Narrow-counter copy driven by the same stimulus to exercise saturation.
   alu_cmd_issuer #(.DATA_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_opcode(alu_opcode2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(alu_result2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
      .rsp_opcode(rsp_opcode2), .rsp_err(rsp_err2),
      .op_count(op_count2), .err_count(err_count2)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("rsp: op=%0d result=%02h err=%0d (expected op=%0d result=%02h err=%0d)",
                     rsp_opcode, rsp_result, rsp_err, e.op, e.res, e.err);
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
            check("rsp_err",    32'(rsp_err),    32'(e.err));
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, output int acc);
      logic hs;
      exp_t e;
      e.res = er;
      e.op  = op;
      e.err = (op == 2'b11);
      exp_q.push_back(e);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      acc = -1;
      for (int i = 0; i < 40; i++) begin
         hs = cmd_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            acc = cyc;
            break;
         end
      end
      cmd_valid = 1'b0;
      check("cmd_accept", 32'(acc >= 0), 32'd1);
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !rsp_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("drain", 32'(done), 32'd1);
   endtask

   initial begin
      int acc, prev;
      logic [7:0] ops_a [3];
      logic [7:0] ops_b [3];
      logic [1:0] ops_o [3];
      logic [7:0] ops_r [3];

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu", {alu_opcode, alu_a, alu_b}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("idle_alu_hold", {alu_opcode, alu_a, alu_b}, 32'd0);
      check("idle_counts", {op_count, err_count}, 32'd0);

      // ADD / SUB / AND with latency check
      ops_o[0] = 2'b00; ops_r[0] = 8'h64;
      ops_o[1] = 2'b01; ops_r[1] = 8'h46;
      ops_o[2] = 2'b10; ops_r[2] = 8'h05;
      for (int i = 0; i < 3; i++) begin
         send(ops_o[i], 8'h55, 8'h0F, ops_r[i], acc);
         check("lat_drive_no_valid", 32'(rsp_valid), 32'd0);
         @(posedge clk);
         #1;
         check("lat_resp_valid", 32'(rsp_valid), 32'd1);
         drain();
      end
      check("op_count_3", 32'(op_count), 32'd3);

      // Wrap and back-to-back
      ops_o[0] = 2'b00; ops_a[0] = 8'hAA; ops_b[0] = 8'h33; ops_r[0] = 8'hDD;
      ops_o[1] = 2'b01; ops_a[1] = 8'hAA; ops_b[1] = 8'h33; ops_r[1] = 8'h77;
      ops_o[2] = 2'b01; ops_a[2] = 8'h00; ops_b[2] = 8'h01; ops_r[2] = 8'hFF;
      prev = -1;
      for (int i = 0; i < 3; i++) begin
         send(ops_o[i], ops_a[i], ops_b[i], ops_r[i], acc);
         if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
         prev = acc;
      end
      drain();
      check("op_count_6", 32'(op_count), 32'd6);

      // Reserved opcode
      send(2'b11, 8'hAA, 8'h33, 8'h00, acc);
      drain();
      check("rsvd_op_count", 32'(op_count), 32'd7);
      check("rsvd_err_count", 32'(err_count), 32'd1);

      // Backpressure with a pending command
      rsp_ready = 1'b0;
      send(2'b00, 8'h11, 8'h22, 8'h33, acc);
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.res = 8'h30; e.op = 2'b01; e.err = 1'b0;
         exp_q.push_back(e);
      end
      cmd_valid = 1'b1; cmd_opcode = 2'b01; cmd_a = 8'h50; cmd_b = 8'h20;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_hold", {rsp_err, rsp_opcode, rsp_result}, {21'd0, 1'b0, 2'b00, 8'h33});
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp_alu_hold", {alu_opcode, alu_a, alu_b}, {14'd0, 2'b00, 8'h11, 8'h22});
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_cmd_ready_follow", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("bp_alu_new", {alu_opcode, alu_a, alu_b}, {14'd0, 2'b01, 8'h50, 8'h20});
      drain();
      check("bp_op_count", 32'(op_count), 32'd9);

      // Reset during DRIVE drops the in-flight SUB
      send(2'b01, 8'h09, 8'h03, 8'h06, acc);
      rst = 1'b1;
      exp_q.delete(exp_q.size() - 1);
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_counts", {op_count, err_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Five ops after reset; narrow copy saturates
      send(2'b00, 8'h01, 8'h02, 8'h03, acc);
      send(2'b01, 8'h10, 8'h01, 8'h0F, acc);
      send(2'b10, 8'hF0, 8'h3C, 8'h30, acc);
      send(2'b11, 8'h12, 8'h34, 8'h00, acc);
      send(2'b00, 8'hFF, 8'h01, 8'h00, acc);
      drain();
      check("final_op_count", 32'(op_count), 32'd5);
      check("final_err_count", 32'(err_count), 32'd1);
      check("sat_op_count", 32'(op_count2), 32'd3);
      check("sat_err_count", 32'(err_count2), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
